// File: rtl/dmem_access_stage.sv
// MEM-stage data-memory access controller.
// Runs a req/ack handshake with a variable-latency data memory, freezes the
// upstream pipeline while an access is outstanding, flags misaligned
// accesses, and aborts an access that gets no ack within TIMEOUT cycles.
`timescale 1ns/1ps
module dmem_access_stage #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] dmdata_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter value of the last ACCESS cycle allowed before aborting.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,    state_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic        req_q,      req_d;
    logic        we_q,       we_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] dmdata_q,   dmdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q,  timeout_d;

    logic        has_req_s;
    logic        aligned_s;
    logic        is_read_s;

    // A request with both enables set is serviced as a write.
    assign has_req_s = memread_i | memwrite_i;
    assign aligned_s = (addr_i[1:0] == 2'b00);
    assign is_read_s = memread_i & ~memwrite_i;

    // Next-state and datapath update for the access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dmdata_d   = dmdata_q;
        misalign_d = 1'b0;
        timeout_d  = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (has_req_s && aligned_s) begin
                    req_d   = 1'b1;
                    we_d    = memwrite_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wdata_i;
                    cnt_d   = 8'd0;
                    state_d = ST_ACCESS;
                end else if (has_req_s) begin
                    // Misaligned: no memory traffic; a load returns zero.
                    misalign_d = 1'b1;
                    if (is_read_s) begin
                        dmdata_d = 32'd0;
                    end else begin
                        dmdata_d = dmdata_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        dmdata_d = mem_rdata_i;
                    end else begin
                        dmdata_d = dmdata_q;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    if (!we_q) begin
                        dmdata_d = ERR_DATA;
                    end else begin
                        dmdata_d = dmdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                // Requests seen here belong to the instruction just served.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Pipeline freeze: while starting an aligned access and throughout ACCESS.
    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE:   stall_o = has_req_s & aligned_s;
            ST_ACCESS: stall_o = 1'b1;
            default:   stall_o = 1'b0;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            dmdata_q   <= 32'd0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dmdata_q   <= dmdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign dmdata_o    = dmdata_q;
    assign misalign_o  = misalign_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_dmem_access_stage.sv
// Bench for dmem_access_stage: directed cases followed by random accesses,
// each judged against a transaction-level model (expected stall length,
// load data and sticky timeout flag derived from the access rules).
`timescale 1ns/1ps
module tb_dmem_access_stage;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        memread_i = 1'b0;
    logic        memwrite_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        stall_o;
    logic [31:0] dmdata_o;
    logic        misalign_o;
    logic        timeout_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_dm = 32'd0;
    logic        exp_to = 1'b0;

    dmem_access_stage #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .memread_i   (memread_i),
        .memwrite_i  (memwrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .dmdata_o    (dmdata_o),
        .misalign_o  (misalign_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
        addr_i     = 32'd0;
        wdata_i    = 32'd0;
    endtask

    // One MEM-stage instruction. Entered and left #1 after a rising edge.
    // lat = ack delay after mem_req_o rises; lat >= TMO means no ack at all.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rdat);
        logic req;
        logic al;
        logic is_rd;
        int   s;
        req   = rd | wr;
        al    = (a[1:0] == 2'b00);
        is_rd = rd & ~wr;
        memread_i  = rd;
        memwrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        if (!req) begin
            // Stray ack in IDLE must be ignored.
            mem_ack_i   = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            @(negedge clk_i);
            chk("idle_stall", 32'(stall_o), 32'd0);
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            chk("idle_req", 32'(mem_req_o), 32'd0);
            chk("idle_dmdata", dmdata_o, exp_dm);
            chk("idle_misalign", 32'(misalign_o), 32'd0);
        end else if (!al) begin
            @(negedge clk_i);
            chk("mis_stall", 32'(stall_o), 32'd0);
            chk("mis_req", 32'(mem_req_o), 32'd0);
            @(posedge clk_i); #1;
            idle_inputs();
            if (is_rd) exp_dm = 32'd0;
            chk("mis_pulse", 32'(misalign_o), 32'd1);
            chk("mis_dmdata", dmdata_o, exp_dm);
            chk("mis_req_after", 32'(mem_req_o), 32'd0);
            @(posedge clk_i); #1;
            chk("mis_pulse_end", 32'(misalign_o), 32'd0);
        end else begin
            s = ((lat < TMO) ? lat : TMO - 1) + 2;
            for (int i = 0; i < s; i++) begin
                mem_ack_i   = (i >= 1) && (i - 1 == lat);
                mem_rdata_i = rdat;
                @(negedge clk_i);
                chk("acc_stall", 32'(stall_o), 32'd1);
                if (i == 0) begin
                    chk("acc_req_before", 32'(mem_req_o), 32'd0);
                end else begin
                    chk("acc_req", 32'(mem_req_o), 32'd1);
                    chk("acc_we", 32'(mem_we_o), 32'(wr));
                    chk("acc_addr", mem_addr_o, {a[31:2], 2'b00});
                    chk("acc_wdata", mem_wdata_o, wd);
                end
                @(posedge clk_i); #1;
            end
            mem_ack_i = 1'b0;
            if (lat < TMO) begin
                if (is_rd) exp_dm = rdat;
            end else begin
                exp_to = 1'b1;
                if (is_rd) exp_dm = ERR;
            end
            // DONE cycle: the same request is still presented.
            @(negedge clk_i);
            chk("done_stall", 32'(stall_o), 32'd0);
            chk("done_req", 32'(mem_req_o), 32'd0);
            chk("done_dmdata", dmdata_o, exp_dm);
            chk("done_timeout", 32'(timeout_o), 32'(exp_to));
            @(posedge clk_i); #1;
            idle_inputs();
            chk("post_req", 32'(mem_req_o), 32'd0);
            chk("post_dmdata", dmdata_o, exp_dm);
            chk("post_timeout", 32'(timeout_o), 32'(exp_to));
        end
    endtask

    task automatic rand_op();
        int          sel;
        logic [31:0] a;
        sel = $urandom_range(0, 3);
        a   = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        do_op(sel == 1 || sel == 3, sel >= 2, a, $urandom, $urandom_range(0, 6), $urandom);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_dmdata", dmdata_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        do_op(1'b1, 1'b0, 32'h10, 32'd0, 0, 32'h1234_5678);
        do_op(1'b0, 1'b1, 32'h20, 32'hCAFE_0001, 3, 32'h7777_7777);
        do_op(1'b1, 1'b0, 32'h22, 32'd0, 0, 32'd0);
        do_op(1'b0, 1'b0, 32'd0, 32'd0, 0, 32'd0);
        do_op(1'b1, 1'b0, 32'h30, 32'd0, 100, 32'd0);
        do_op(1'b1, 1'b0, 32'h34, 32'd0, 0, 32'h0BAD_F00D);
        do_op(1'b1, 1'b0, 32'h44, 32'd0, 1, 32'h1111_2222);
        do_op(1'b0, 1'b1, 32'h48, 32'h3333_4444, 2, 32'h5555_6666);
        do_op(1'b1, 1'b1, 32'h50, 32'h9999_0000, 1, 32'hABCD_EF01);
        do_op(1'b0, 1'b1, 32'h51, 32'h0, 0, 32'd0);

        for (int n = 0; n < 40; n++) rand_op();

        // Reset in the middle of a write access, between clock edges.
        memwrite_i = 1'b1;
        addr_i     = 32'h60;
        wdata_i    = 32'h5555_AAAA;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        exp_dm = 32'd0;
        exp_to = 1'b0;
        chk("arst_req", 32'(mem_req_o), 32'd0);
        chk("arst_we", 32'(mem_we_o), 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        chk("arst_wdata", mem_wdata_o, 32'd0);
        chk("arst_dmdata", dmdata_o, 32'd0);
        chk("arst_misalign", 32'(misalign_o), 32'd0);
        chk("arst_timeout", 32'(timeout_o), 32'd0);
        chk("arst_stall_req", 32'(stall_o), 32'd1);
        idle_inputs();
        #1;
        chk("arst_stall_noreq", 32'(stall_o), 32'd0);
        @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFEED_FACE;
        @(negedge clk_i);
        chk("late_ack_stall", 32'(stall_o), 32'd0);
        chk("late_ack_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        chk("late_ack_dmdata", dmdata_o, 32'd0);
        chk("late_ack_req2", 32'(mem_req_o), 32'd0);
        chk("late_ack_timeout", 32'(timeout_o), 32'd0);

        for (int n = 0; n < 15; n++) rand_op();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_stage.md
# dmem_access_stage

Data-memory access controller for the MEM stage of the 5-stage pipeline. It consumes the memory-control and address/data outputs of the EX/MEM pipeline register, runs a req/ack handshake with an external variable-latency data memory, and freezes the upstream pipeline while an access is outstanding. Its `dmdata_o` feeds the MEM/WB pipeline register's data-memory input.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum ACCESS cycles without `mem_ack_i` before the access is aborted (≥1, ≤255).
- `ERR_DATA`, default 32'hDEAD_BEEF: value returned on `dmdata_o` for an aborted read.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `memread_i`  in  1  load request from EX/MEM.
- `memwrite_i`  in  1  store request from EX/MEM.
- `addr_i`  in  32  byte address (EX/MEM ALU result).
- `wdata_i`  in  32  store data (EX/MEM rt data).
- `mem_req_o`  out  1  request to data memory, registered.
- `mem_we_o`  out  1  1 = write, 0 = read; registered, valid while `mem_req_o`=1.
- `mem_addr_o`  out  32  registered word address (`addr_i` with [1:0] forced to 0).
- `mem_wdata_o`  out  32  registered store data.
- `mem_ack_i`  in  1  memory completion, one-cycle pulse.
- `mem_rdata_i`  in  32  read data, valid with `mem_ack_i`.
- `stall_o`  out  1  combinational; 1 freezes PC, IF/ID, ID/EX, EX/MEM.
- `dmdata_o`  out  32  registered load data to MEM/WB.
- `misalign_o`  out  1  registered one-cycle pulse on a misaligned access.
- `timeout_o`  out  1  sticky error flag, cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request (`memread_i`=`memwrite_i`=0): stay in IDLE, `stall_o`=0, `dmdata_o` holds its value.
- IDLE, request with `addr_i[1:0]`≠0: no memory request; `misalign_o`=1 next cycle; a read loads `dmdata_o`=0; stay in IDLE; `stall_o`=0.
- IDLE, aligned request: `stall_o`=1 in this cycle. On the edge, latch address/data/we, set `mem_req_o`=1, clear the timeout counter, go to ACCESS.
- Both `memread_i` and `memwrite_i` set: treated as a write.
- ACCESS: `stall_o`=1, `mem_req_o` held with stable address/data/we.
  - On `mem_ack_i`=1: drop `mem_req_o`. A read loads `dmdata_o`←`mem_rdata_i`; a write leaves `dmdata_o` unchanged. Go to DONE.
  - No ack: the counter increments. When the counter reaches TIMEOUT-1 with no ack: drop `mem_req_o`, set `timeout_o`; a read loads `dmdata_o`←ERR_DATA. Go to DONE.
- DONE: `stall_o`=0, so the pipeline advances on this edge and MEM/WB captures `dmdata_o`. Always return to IDLE. Requests present during DONE are ignored; they belong to the already-served instruction.
- `mem_ack_i` outside ACCESS is ignored.
- Reset (any time, including mid-ACCESS): immediately `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `dmdata_o`=0, `misalign_o`=0, `timeout_o`=0; state IDLE; counter 0. `stall_o` is then 0 unless a request is present.

## Timing
- Non-memory instruction: 1 cycle in MEM, no stall.
- Aligned access, ack N cycles after `mem_req_o` rises (N=0 means ack in the first ACCESS cycle): `stall_o` high for N+2 cycles (IDLE + N+1 ACCESS cycles), then 1 DONE cycle. Minimum MEM occupancy is 3 cycles.
- Timeout: `stall_o` high for TIMEOUT+1 cycles. `timeout_o` rises on the same edge that enters DONE.
- `dmdata_o` is stable throughout DONE and through the following IDLE cycle until the next read completes.
- Back-to-back accesses: IDLE is re-entered for 1 cycle between them; `mem_req_o` deasserts for ≥2 cycles.

## Test plan
- Reset, then aligned read at 0x10; memory acks in the first ACCESS cycle with 0x1234_5678 -> `mem_req_o`=1 for 1 cycle, `mem_we_o`=0, `stall_o`=1 for 2 cycles, `dmdata_o`=0x1234_5678 in DONE.
- Write 0xCAFE_0001 to 0x20, ack after 3 cycles -> `mem_we_o`=1, `mem_addr_o`=0x20, `mem_wdata_o`=0xCAFE_0001 stable for 4 cycles; `stall_o` high for 5 cycles; `dmdata_o` unchanged.
- Read at 0x22 -> no `mem_req_o`, `misalign_o` pulses 1 cycle, `dmdata_o`=0, `stall_o`=0.
- Read with no ack, TIMEOUT=4 -> `stall_o` high for 5 cycles, `mem_req_o` drops, `timeout_o`=1 and stays set, `dmdata_o`=0xDEAD_BEEF; a following read with immediate ack succeeds while `timeout_o` remains 1.
- Assert `rst_i` mid-ACCESS, between clock edges -> `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `dmdata_o`, `misalign_o` and `timeout_o` go to 0 without waiting for a clock edge; state is IDLE. A late `mem_ack_i` after reset release is ignored.
- Back-to-back read then write -> two distinct `mem_req_o` pulses separated by ≥2 low cycles; requests held during DONE are not reissued.
